logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, cycles operands are held on the shared unit before capture; legal range 1..15.
REQ-002 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Ports: req0_valid / req1_valid  in  1  requester N has an operation pending.
REQ-005 Ports: req0_ready / req1_ready  out  1  requester N accepted this cycle when valid&ready.
REQ-006 Ports: req0_a, req0_b / req1_a, req1_b  in  32  operands.
REQ-007 Ports: req0_nand / req1_nand  in  1  1 = NAND, 0 = AND.
REQ-008 Ports: rsp0_valid / rsp1_valid  out  1  result for requester N available.
REQ-009 Ports: rsp0_ready / rsp1_ready  in  1  requester N consumes result.
REQ-010 Ports: rsp_data  out  32  result, shared by both response channels.
REQ-011 Ports: unit_a, unit_b  out  32; unit_andflag  out  1; unit_out  in  32  connection to the shared 32-bit AND/NAND unit (andflag=1 selects NAND).
REQ-012 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, SETTLE, RESP.
REQ-014 IDLE: reqN_ready=1 only for the granted requester; grant = sole valid requester, or pointer holder when both valid; no ready when none valid.
REQ-015 Acceptance (valid&ready in IDLE) registers a, b, nand into unit_a, unit_b, unit_andflag, records grantee, loads counter with SETTLE_CYCLES-1, moves to SETTLE.
REQ-016 SETTLE: counter decrements each cycle; when counter is 0, rsp_data <= unit_out and state -> RESP; SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
REQ-017 RESP: rspN_valid=1 for grantee only; rsp_data stable; stays in RESP until rspN_ready=1, then -> IDLE.
REQ-018 Latency: acceptance in cycle 0 -> rsp valid first in cycle SETTLE_CYCLES+1; next acceptance earliest cycle after response handshake.
REQ-019 Round-robin: on each acceptance the pointer moves to the non-granted requester; the pointer is unchanged in cycles without acceptance.
REQ-020 unit_a/unit_b/unit_andflag change only on acceptance; requester operand changes after acceptance have no effect.
REQ-021 reqN_ready=0 in SETTLE and RESP; requests made then wait, not dropped.
REQ-022 rspN_valid never asserted for both requesters in the same cycle.
REQ-023 No carryout or overflow handling; the block passes unit_out unmodified.

Reset
REQ-024 reset=1 at a clock edge: state IDLE, pointer = requester 0, counter 0, unit_a=unit_b=0, unit_andflag=0, rsp_data=0, grantee 0.
REQ-025 All ready/valid outputs and busy are 0 during the reset cycle.
REQ-026 Reset during SETTLE or RESP aborts the transaction; no response is ever issued for it.

Structure
REQ-027 Shared package logic_unit_pkg holds the FSM state typedef, WORD_WIDTH=32, and SETTLE_CYCLES bounds.
REQ-028 One sub-module: rr_arbiter2 (two-way round-robin grant with pointer update on accept); the FSM, counter, and operand/result registers remain in logic_unit_arbiter.

Verification (SETTLE_CYCLES=2, AND/NAND unit model attached)
REQ-029 req0 a=0xFFFF0000 b=0x0F0F0F0F nand=0 accepted in cycle 0 -> rsp0_valid in cycle 3, rsp_data=0x0F0F0000.
REQ-030 Same operands nand=1 on req1 -> unit_andflag=1, rsp1_valid with rsp_data=0xF0F0FFFF.
REQ-031 Both valid from reset with continuous requests and rsp_ready held 1 -> grant order 0,1,0,1; one accept every 4 cycles.
REQ-032 rsp0_ready held 0 for 5 cycles in RESP -> rsp0_valid and rsp_data held, busy=1, req1_ready=0 throughout.
REQ-033 reset pulsed during SETTLE -> next cycle IDLE, all outputs zero, no rsp for the aborted op, pointer = requester 0.
REQ-034 req0_a changed to 0x12345678 the cycle after acceptance -> unit_a keeps the accepted value until the next acceptance.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit arbiter: word width, settle-count
// bounds and the FSM state type.
package logic_unit_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned SETTLE_MIN = 1;
    localparam int unsigned SETTLE_MAX = 15;
    // Wide enough to hold SETTLE_MAX-1
    localparam int unsigned CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins
// when both are valid; on every accept it moves to the requester that lost.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   valid0, valid1      pending requests
//   enable              arbitration allowed this cycle
//   grant0, grant1      one-hot grant (combinational, gated by enable)
//   accept              a grant was issued this cycle
//   grant_idx           index of the granted requester
//   pointer             current round-robin priority holder
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic enable,
    output logic grant0,
    output logic grant1,
    output logic accept,
    output logic grant_idx,
    output logic pointer
);

    // Sole valid requester wins; pointer breaks a tie
    assign grant_idx = (valid0 && valid1) ? pointer : valid1;
    assign grant0    = enable && valid0 && !grant_idx;
    assign grant1    = enable && valid1 &&  grant_idx;
    assign accept    = grant0 || grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            pointer <= 1'b0;
        end else if (accept) begin
            pointer <= !grant_idx;
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Arbitrates two requesters onto one shared 32-bit AND/NAND unit. An accepted
// request's operands are held on the unit for SETTLE_CYCLES cycles, the
// result is captured and presented on the grantee's response channel until
// consumed.
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   reqN_valid/ready              request handshake per requester
//   reqN_a, reqN_b, reqN_nand     operands and op select (1 = NAND)
//   rspN_valid/ready              response handshake per requester
//   rsp_data                      captured result, shared by both channels
//   unit_a, unit_b, unit_andflag  operands driven to the shared unit
//   unit_out                      result from the shared unit
//   busy                          transaction in flight
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_nand,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_nand,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        unit_andflag,
    input  logic [31:0] unit_out,
    output logic        busy
);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 grantee;
    logic                 accept;
    logic                 grant_idx;
    logic                 pointer;
    logic                 rsp_ready_sel;

    // Arbitration only in IDLE; reset masks every handshake output
    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .enable    ((state == IDLE) && !reset),
        .grant0    (req0_ready),
        .grant1    (req1_ready),
        .accept    (accept),
        .grant_idx (grant_idx),
        .pointer   (pointer)
    );

    assign rsp0_valid    = !reset && (state == RESP) && !grantee;
    assign rsp1_valid    = !reset && (state == RESP) &&  grantee;
    assign busy          = !reset && (state != IDLE);
    assign rsp_ready_sel = grantee ? rsp1_ready : rsp0_ready;

    // Transaction FSM with operand/result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            grantee      <= 1'b0;
            unit_a       <= '0;
            unit_b       <= '0;
            unit_andflag <= 1'b0;
            rsp_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        unit_a       <= grant_idx ? req1_a    : req0_a;
                        unit_b       <= grant_idx ? req1_b    : req0_b;
                        unit_andflag <= grant_idx ? req1_nand : req0_nand;
                        grantee      <= grant_idx;
                        cnt          <= CNT_WIDTH'(SETTLE_CYCLES - 1);
                        state        <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Capture on the last settle cycle
                    if (cnt == '0) begin
                        rsp_data <= unit_out;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_sel) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with SETTLE_CYCLES=2 and an AND/NAND
// unit model attached.
module tb_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_nand;
    logic        req1_valid, req1_ready, req1_nand;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_data, unit_a, unit_b, unit_out;
    logic        unit_andflag, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Shared unit model: andflag=1 selects NAND
    assign unit_out = unit_andflag ? ~(unit_a & unit_b) : (unit_a & unit_b);

    logic_unit_arbiter #(.SETTLE_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_nand    (req0_nand),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_nand    (req1_nand),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp_data     (rsp_data),
        .unit_a       (unit_a),
        .unit_b       (unit_b),
        .unit_andflag (unit_andflag),
        .unit_out     (unit_out),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_nand = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_nand = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset cycle: handshakes and busy masked, registers cleared
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check1("rst_req0_ready", req0_ready, 1'b0);
        check1("rst_req1_ready", req1_ready, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_rsp0_valid", rsp0_valid, 1'b0);
        check1("rst_rsp1_valid", rsp1_valid, 1'b0);
        check32("rst_unit_a", unit_a, 32'h0);
        check32("rst_rsp_data", rsp_data, 32'h0);
        check1("rst_andflag", unit_andflag, 1'b0);
        tick();

        // AND on requester 0, accepted in cycle 0
        reset = 1'b0; req1_valid = 1'b0;
        req0_a = 32'hFFFF_0000; req0_b = 32'h0F0F_0F0F; req0_nand = 1'b0;
        #1;
        check1("c0_req0_ready", req0_ready, 1'b1);
        check1("c0_req1_ready", req1_ready, 1'b0);
        check1("c0_busy", busy, 1'b0);
        tick();

        // Cycle 1: operand change after acceptance must not reach the unit
        req0_valid = 1'b0; req0_a = 32'h1234_5678;
        #1;
        check1("c1_busy", busy, 1'b1);
        check1("c1_req0_ready", req0_ready, 1'b0);
        check1("c1_rsp0_valid", rsp0_valid, 1'b0);
        check32("c1_unit_a", unit_a, 32'hFFFF_0000);
        check32("c1_unit_b", unit_b, 32'h0F0F_0F0F);
        check1("c1_andflag", unit_andflag, 1'b0);
        tick();

        #1;
        check1("c2_rsp0_valid", rsp0_valid, 1'b0);
        check32("c2_unit_a", unit_a, 32'hFFFF_0000);
        tick();

        // Cycle 3 onwards: response held while rsp0_ready low, req1 waits
        req1_valid = 1'b1;
        req1_a = 32'hFFFF_0000; req1_b = 32'h0F0F_0F0F; req1_nand = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check1("hold_rsp0_valid", rsp0_valid, 1'b1);
            check1("hold_rsp1_valid", rsp1_valid, 1'b0);
            check32("hold_rsp_data", rsp_data, 32'h0F0F_0000);
            check1("hold_busy", busy, 1'b1);
            check1("hold_req1_ready", req1_ready, 1'b0);
            tick();
        end
        rsp0_ready = 1'b1;
        #1;
        check1("hs0_rsp0_valid", rsp0_valid, 1'b1);
        tick();

        // Waiting requester 1 is granted once back in IDLE
        rsp0_ready = 1'b0;
        #1;
        check1("g1_req1_ready", req1_ready, 1'b1);
        check1("g1_req0_ready", req0_ready, 1'b0);
        check1("g1_busy", busy, 1'b0);
        check1("g1_rsp0_valid", rsp0_valid, 1'b0);
        tick();

        req1_valid = 1'b0;
        #1;
        check1("n1_andflag", unit_andflag, 1'b1);
        check1("n1_req1_ready", req1_ready, 1'b0);
        tick();
        tick();
        rsp1_ready = 1'b1;
        #1;
        check1("n1_rsp1_valid", rsp1_valid, 1'b1);
        check1("n1_rsp0_valid", rsp0_valid, 1'b0);
        check32("n1_rsp_data", rsp_data, 32'hF0F0_FFFF);
        tick();

        // Abort: reset during SETTLE
        rsp1_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'hFFFF_FFFF; req0_nand = 1'b0;
        #1;
        check1("ab_req0_ready", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        #1;
        check1("ab_busy", busy, 1'b1);
        check32("ab_unit_a", unit_a, 32'h1234_5678);
        tick();
        reset = 1'b1;
        #1;
        check1("ab_rst_busy", busy, 1'b0);
        check1("ab_rst_rsp0_valid", rsp0_valid, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check1("ab_idle_busy", busy, 1'b0);
        check32("ab_idle_unit_a", unit_a, 32'h0);
        check32("ab_idle_rsp_data", rsp_data, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check1("ab_no_rsp0", rsp0_valid, 1'b0);
            check1("ab_no_busy", busy, 1'b0);
        end

        // Both requesting continuously from a freshly reset pointer
        req0_valid = 1'b1; req0_a = 32'hAAAA_5555; req0_b = 32'hFFFF_0000; req0_nand = 1'b0;
        req1_valid = 1'b1; req1_a = 32'hAAAA_5555; req1_b = 32'h0000_FFFF; req1_nand = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            check1("rr_req0_ready", req0_ready, (k % 4 == 0) && ((k / 4) % 2 == 0));
            check1("rr_req1_ready", req1_ready, (k % 4 == 0) && ((k / 4) % 2 == 1));
            check1("rr_rsp0_valid", rsp0_valid, (k % 4 == 3) && ((k / 4) % 2 == 0));
            check1("rr_rsp1_valid", rsp1_valid, (k % 4 == 3) && ((k / 4) % 2 == 1));
            if (k % 4 == 3) begin
                check32("rr_rsp_data", rsp_data,
                        ((k / 4) % 2 == 0) ? 32'hAAAA_0000 : 32'hFFFF_AAAA);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
